// File: rtl/race_cycle_sequencer_if.sv
// Control and datapath signals of the race-logic cycle sequencer.
// master: the binary control domain plus the temporal primitive it drives.
// slave:  the sequencer itself.
interface race_cycle_sequencer_if #(
    parameter int T_BITS = 3,
    parameter int N_IN   = 2
);
    logic                     start;
    logic                     cfg_falling;
    logic [N_IN-1:0]          in_en;
    logic [N_IN*T_BITS-1:0]   in_time;
    logic                     busy;
    logic                     done;
    logic                     out_valid;
    logic [T_BITS-1:0]        out_time;
    logic                     dp_rst;
    logic [N_IN-1:0]          tx;
    logic                     dp_q;

    modport master (
        output start, cfg_falling, in_en, in_time, dp_q,
        input  busy, done, out_valid, out_time, dp_rst, tx
    );

    modport slave (
        input  start, cfg_falling, in_en, in_time, dp_q,
        output busy, done, out_valid, out_time, dp_rst, tx
    );
endinterface

// File: rtl/race_cycle_sequencer.sv
// Sequences one gamma cycle of a race-logic primitive: latch binary spike
// times, hold the primitive in reset, replay each spike as an edge at its
// tick, then time the primitive's output edge back into a binary value.
module race_cycle_sequencer #(
    parameter int T_BITS      = 3,
    parameter int N_IN        = 2,
    parameter int RST_CYCLES  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 aclk,
    input  logic                 grst_n,
    race_cycle_sequencer_if.slave bus
);
    // The run window covers every spike time plus the synchroniser delay,
    // so an output edge caused by the latest possible spike is still seen.
    localparam int RUN_LEN = (1 << T_BITS) + SYNC_STAGES;
    localparam int CW      = $clog2(RUN_LEN + RST_CYCLES + 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] RUN_LAST = CW'(RUN_LEN - 1);
    localparam logic [CW-1:0] SYNC_W   = CW'(SYNC_STAGES);

    typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

    state_t                         state_q;
    logic [CW-1:0]                  cnt_q;
    logic                           falling_q;
    logic [N_IN-1:0]                en_q;
    logic [N_IN-1:0][T_BITS-1:0]    time_q;
    logic [SYNC_STAGES-1:0]         sync_q;
    logic                           cap_q;
    logic                           busy_q;
    logic                           done_q;
    logic                           out_valid_q;
    logic                           dp_rst_q;
    logic [T_BITS-1:0]              out_time_q;
    logic [N_IN-1:0]                tx_q;

    logic [CW-1:0]                  tick_d;
    logic [N_IN-1:0]                fire_d;
    logic                           q_s;
    logic                           cap_now;
    logic [T_BITS-1:0]              cap_time;

    assign q_s = sync_q[SYNC_STAGES-1];

    // Tick that becomes current after this edge, which inputs are active in
    // it, and whether the synchronised output edge is captured this tick.
    always_comb begin
        tick_d = '0;
        fire_d = '0;
        if (state_q == S_RUN) begin
            tick_d = cnt_q + 1'b1;
        end
        for (int i = 0; i < N_IN; i++) begin
            fire_d[i] = en_q[i] && (tick_d >= CW'(time_q[i]));
        end
        cap_now  = (state_q == S_RUN) && !cap_q && (q_s != falling_q);
        cap_time = (cnt_q >= SYNC_W) ? T_BITS'(cnt_q - SYNC_W) : '0;
    end

    // Synchroniser for the asynchronous primitive output; primed with the
    // idle level during local reset so stale levels never look like an edge.
    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            sync_q <= '0;
        end else if (state_q == S_RESET) begin
            sync_q <= {SYNC_STAGES{falling_q}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.dp_q};
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            falling_q   <= 1'b0;
            en_q        <= '0;
            time_q      <= '0;
            cap_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_time_q  <= '0;
            dp_rst_q    <= 1'b1;
            tx_q        <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        en_q        <= bus.in_en;
                        time_q      <= bus.in_time;
                        falling_q   <= bus.cfg_falling;
                        tx_q        <= {N_IN{bus.cfg_falling}};
                        out_valid_q <= 1'b0;
                        out_time_q  <= '0;
                        cap_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= S_RESET;
                    end
                end
                S_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        cnt_q    <= '0;
                        dp_rst_q <= 1'b0;
                        state_q  <= S_RUN;
                        // tick_d is 0 here, so in_time=0 fires in tick 0
                        for (int i = 0; i < N_IN; i++) begin
                            if (fire_d[i]) tx_q[i] <= ~falling_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (cap_now) begin
                        cap_q      <= 1'b1;
                        out_time_q <= cap_time;
                    end
                    if (cnt_q == RUN_LAST) begin
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        out_valid_q <= cap_q | cap_now;
                        if (!cap_q && !cap_now) out_time_q <= '1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        // Transitions are one-way: once active, stay active
                        for (int i = 0; i < N_IN; i++) begin
                            if (fire_d[i]) tx_q[i] <= ~falling_q;
                        end
                    end
                end
                S_DONE: begin
                    busy_q   <= 1'b0;
                    dp_rst_q <= 1'b1;
                    cnt_q    <= '0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_time  = out_time_q;
    assign bus.dp_rst    = dp_rst_q;
    assign bus.tx        = tx_q;
endmodule

// File: tb/tb_race_cycle_sequencer.sv
// Bench for race_cycle_sequencer driving a two-input max primitive.
// Expected results come from the race-logic rules: each enabled input is
// active from its spike time on, and the primitive fires at the latest spike
// only when every input spikes.
module tb_race_cycle_sequencer;
    localparam int T_BITS = 3;
    localparam int N_IN   = 2;
    localparam int RUN_LEN = (1 << T_BITS) + 2;
    localparam int DONE_AT = 2 + RUN_LEN + 1;

    logic aclk;
    logic grst_n;
    logic mode_fall;
    int   n_assert;
    int   n_fail;

    race_cycle_sequencer_if #(.T_BITS(T_BITS), .N_IN(N_IN)) bus();

    race_cycle_sequencer #(
        .T_BITS(T_BITS), .N_IN(N_IN), .RST_CYCLES(2), .SYNC_STAGES(2)
    ) dut (
        .aclk   (aclk),
        .grst_n (grst_n),
        .bus    (bus.slave)
    );

    // Max primitive: rising encoding fires when all inputs rose, falling
    // encoding when all inputs fell; held at idle level while in reset.
    assign bus.dp_q = bus.dp_rst ? mode_fall
                    : (mode_fall ? |bus.tx : &bus.tx);

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] tx_ref(input logic [1:0] en, input int a, input int b,
                                          input logic fall, input int t);
        logic [1:0] r;
        r[0] = (en[0] && t >= a) ? ~fall : fall;
        r[1] = (en[1] && t >= b) ? ~fall : fall;
        return r;
    endfunction

    // One gamma cycle. dup_tick >= 0 pulses a conflicting start at that RUN
    // tick; rst_tick >= 0 pulls grst_n low at that RUN tick.
    task automatic run(input logic [1:0] en, input int a, input int b, input logic fall,
                       input int dup_tick, input int rst_tick);
        logic       exp_valid;
        logic [2:0] exp_time;
        int         t;
        exp_valid = (en == 2'b11);
        exp_time  = exp_valid ? 3'((a > b) ? a : b) : 3'd7;

        @(negedge aclk);
        bus.in_en       = en;
        bus.in_time     = {3'(b), 3'(a)};
        bus.cfg_falling = fall;
        mode_fall       = fall;
        bus.start       = 1'b1;

        for (int n = 1; n <= DONE_AT + 1; n++) begin
            @(posedge aclk);
            #1;
            if (n == 1) bus.start = 1'b0;
            t = n - 3;
            chk("busy", bus.busy, n <= DONE_AT);
            chk("done", bus.done, n == DONE_AT);
            chk("dp_rst", bus.dp_rst, n <= 2 || n > DONE_AT);
            if (n <= 2)
                chk("tx_reset", bus.tx, {2{fall}});
            else if (t < RUN_LEN)
                chk("tx_run", bus.tx, tx_ref(en, a, b, fall, t));
            else
                chk("tx_hold", bus.tx, tx_ref(en, a, b, fall, RUN_LEN - 1));
            if (n >= DONE_AT) begin
                chk("out_valid", bus.out_valid, exp_valid);
                chk("out_time", bus.out_time, exp_time);
            end else begin
                chk("out_valid_clr", bus.out_valid, 1'b0);
            end

            if (dup_tick >= 0 && t == dup_tick) begin
                bus.start       = 1'b1;
                bus.in_en       = 2'b00;
                bus.in_time     = 6'h3f;
                bus.cfg_falling = ~fall;
            end else if (dup_tick >= 0 && t == dup_tick + 1) begin
                bus.start = 1'b0;
            end

            if (rst_tick >= 0 && t == rst_tick) begin
                grst_n = 1'b0;
                #1;
                chk("abort_busy", bus.busy, 1'b0);
                chk("abort_done", bus.done, 1'b0);
                chk("abort_dp_rst", bus.dp_rst, 1'b1);
                chk("abort_tx", bus.tx, 2'b00);
                chk("abort_valid", bus.out_valid, 1'b0);
                chk("abort_time", bus.out_time, 3'd0);
                repeat (2) begin
                    @(negedge aclk);
                    chk("abort_no_done", bus.done, 1'b0);
                end
                grst_n = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        mode_fall = 1'b0;
        bus.start = 1'b0;
        bus.cfg_falling = 1'b0;
        bus.in_en = '0;
        bus.in_time = '0;
        grst_n = 1'b0;
        repeat (2) @(negedge aclk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_time", bus.out_time, 3'd0);
        chk("rst_dp_rst", bus.dp_rst, 1'b1);
        chk("rst_tx", bus.tx, 2'b00);
        grst_n = 1'b1;

        run(2'b11, 2, 5, 1'b0, -1, -1);
        run(2'b11, 6, 1, 1'b0, -1, -1);
        run(2'b11, 3, 3, 1'b0, -1, -1);
        run(2'b11, 0, 4, 1'b1, -1, -1);
        run(2'b01, 2, 5, 1'b0, -1, -1);
        run(2'b11, 2, 5, 1'b0,  3, -1);
        run(2'b11, 2, 5, 1'b0, -1,  4);
        run(2'b11, 1, 2, 0, -1, -1);
        run(2'b11, 7, 7, 1'b1, -1, -1);
        run(2'b10, 0, 0, 1'b1, -1, -1);

        for (int k = 0; k < 24; k++) begin
            run(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/race_cycle_sequencer.md
Name: race_cycle_sequencer

Overview:
- Sequences one gamma cycle of a temporal (race-logic) primitive such as the exclusive max unit.
- Latches binary spike times, holds the primitive in local reset, then replays each input as an edge transition at its scheduled tick.
- Times the primitive's output edge and converts it back to a binary time with a done pulse.
- Sits between the binary control domain and the temporal datapath; `dp_rst`, `tx` and `dp_q` connect directly to the primitive's `rst`, inputs and `q`.

Parameters:
- T_BITS, 3: time resolution; spike times range 0..2^T_BITS-1.
- N_IN, 2: number of temporal inputs driven into the datapath.
- RST_CYCLES, 2: cycles `dp_rst` is held high before each run (minimum 1).
- SYNC_STAGES, 2: flops synchronising `dp_q` into `aclk` (minimum 2).

Ports:
- aclk  in  1  clock.
- grst_n  in  1  global reset, asynchronous, active-low.
- start  in  1  request a gamma cycle; accepted only in IDLE.
- cfg_falling  in  1  0 = rising-edge encoding, 1 = falling-edge encoding; latched on start.
- in_en  in  N_IN  per-input spike enable; disabled inputs never transition.
- in_time  in  N_IN*T_BITS  per-input spike time; input i occupies bits [i*T_BITS +: T_BITS].
- busy  out  1  high from accepted start until the done cycle inclusive.
- done  out  1  one-cycle pulse at the end of the run.
- out_valid  out  1  output edge observed in the window; held until the next accepted start.
- out_time  out  T_BITS  decoded output time; held until the next accepted start.
- dp_rst  out  1  local reset to the datapath primitive, active-high.
- tx  out  N_IN  edge-encoded inputs to the datapath.
- dp_q  in  1  datapath output; asynchronous relative to aclk.

Behaviour:
- Reset values (grst_n low, asynchronous):
  - State is IDLE; busy=0, done=0, out_valid=0, out_time=0.
  - dp_rst=1, tx=0; counters, latches and sync flops cleared.
- Idle level L = latched cfg_falling (0 rising, 1 falling). Active level = ~L.
- FSM IDLE -> RESET -> RUN -> DONE -> IDLE.
- IDLE:
  - dp_rst=1; tx holds its last value.
  - start=1 latches in_en, in_time and cfg_falling.
  - On start: clear out_valid and out_time to 0, set busy=1, go to RESET.
- RESET:
  - Lasts exactly RST_CYCLES cycles; dp_rst=1, tx=L on all bits.
  - Sync-chain shadows are loaded with L.
- RUN:
  - dp_rst=0. Tick counter t runs 0..RUN_LEN-1, where RUN_LEN = 2^T_BITS + SYNC_STAGES.
  - tx[i] is at the active level in RUN tick t iff in_en[i]=1 and t >= in_time[i]. The transition happens once; tx never returns to L within the run.
  - dp_q passes through SYNC_STAGES flops to give q_s.
  - Capture: the first RUN tick with q_s != L and no capture yet records out_time = t - SYNC_STAGES, saturating at 0, and sets a capture flag. Later changes of q_s are ignored.
  - After tick RUN_LEN-1, go to DONE.
- DONE:
  - One cycle; done=1, busy=1, dp_rst=0, tx held.
  - out_valid = capture flag; if no capture, out_time = all ones.
  - Then go to IDLE; dp_rst=1 and busy=0 from the next cycle.
- Latency: done rises exactly RST_CYCLES + RUN_LEN + 1 cycles after the cycle start is accepted, independent of the data. With defaults this is 2+10+1 = 13.
- start while busy is ignored; no queueing and no effect on latched values.
- Precedence:
  - Simultaneous spikes (equal in_time) transition in the same tick.
  - in_time=0 transitions in the first RUN tick.
- Mid-operation reset: grst_n low in any state aborts immediately to the reset values.
  - No done pulse.
  - The next start after release runs a full normal cycle.

Test Plan:
- Defaults, rising, in_en=11, a=2, b=5, datapath = exclusive max -> done 13 cycles after start, out_valid=1, out_time=5; tx[0] active from tick 2, tx[1] from tick 5.
- Rising, a=6, b=1 -> out_time=6. Rising, a=3, b=3 -> out_time=3, both tx transition in the same tick.
- cfg_falling=1, a=0, b=4 -> tx idle high in RESET, falls at ticks 0 and 4; out_time=4, out_valid=1.
- in_en=01, a=2 (exclusive max never fires) -> out_valid=0, out_time=7, done still at cycle 13.
- start pulsed again at RUN tick 3 with different in_time -> ignored; results match the first request; busy stays high throughout.
- grst_n low at RUN tick 4 -> immediately dp_rst=1, tx=0, busy=0, no done. After release, a new start with a=1, b=2 -> out_time=2.
